// File: rtl/pipe_ctrl_pkg.sv
// Shared state encoding and opcode constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_ACC  = 2'd1,
        LOAD_USE = 2'd2,
        FLUSH    = 2'd3
    } ctrl_state_t;

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SB = 6'b101000;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB) || (op == OP_SW) || (op == OP_SB);
    endfunction

    function automatic logic is_load_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LB);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline stages (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic        ex_valid;
    logic [5:0]  ex_op;
    logic        ex_taken;
    logic [4:0]  ex_dst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_use_rs;
    logic        id_use_rt;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        flush_if_id;
    logic        flush_id_ex;
    logic        sram_owner;
    logic        mem_timeout;
    ctrl_state_t ctrl_state;
    logic [31:0] stat_stall;
    logic [31:0] stat_flush;

    modport master (
        output ex_valid, ex_op, ex_taken, ex_dst, id_rs, id_rt, id_use_rs, id_use_rt, mem_ack,
        input  stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, sram_owner,
               mem_timeout, ctrl_state, stat_stall, stat_flush
    );

    modport slave (
        input  ex_valid, ex_op, ex_taken, ex_dst, id_rs, id_rt, id_use_rs, id_use_rt, mem_ack,
        output stall_if, stall_id, bubble_ex, flush_if_id, flush_id_ex, sram_owner,
               mem_timeout, ctrl_state, stat_stall, stat_flush
    );

endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with enable and synchronous clear.
module pipe_sat_counter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [DATA_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (en && (count != {DATA_W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; also arbitrates the shared SRAM port.
// Optional statistics counters are built when PIPE_CTRL_STATS_EN is defined.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_HOLD      = 1,
    parameter int LOAD_USE_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    localparam logic [7:0] FLUSH_HOLD_C = 8'(FLUSH_HOLD);
    localparam logic [7:0] LOAD_USE_C   = 8'(LOAD_USE_CYCLES);

    ctrl_state_t state;
    logic [7:0]  cnt;
    logic [7:0]  tmo;
    logic [7:0]  tmo_next;
    logic        ld_is_load;
    logic [4:0]  ld_dst;
    logic        timeout_flag;

    logic        taken_run;
    logic        mem_run;
    logic        load_hazard;
    logic        stall;
    logic        flush;
    logic        owner;

    assign taken_run = (state == RUN) && bus.ex_valid && bus.ex_taken;
    assign mem_run   = (state == RUN) && bus.ex_valid && !bus.ex_taken && is_mem_op(bus.ex_op);
    assign tmo_next  = (tmo == 8'hFF) ? tmo : tmo + 8'd1;

    // $0 is hardwired, so a load targeting it can never feed a later reader.
    assign load_hazard = ld_is_load && (ld_dst != 5'd0) && (LOAD_USE_CYCLES > 0) &&
                         ((bus.id_use_rs && (bus.id_rs == ld_dst)) ||
                          (bus.id_use_rt && (bus.id_rt == ld_dst)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            cnt          <= '0;
            tmo          <= '0;
            ld_is_load   <= 1'b0;
            ld_dst       <= '0;
            timeout_flag <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (taken_run) begin
                        if (FLUSH_HOLD > 0) begin
                            state <= FLUSH;
                            cnt   <= FLUSH_HOLD_C;
                        end
                    end else if (mem_run) begin
                        state      <= MEM_ACC;
                        tmo        <= '0;
                        ld_is_load <= is_load_op(bus.ex_op);
                        ld_dst     <= bus.ex_dst;
                    end
                end
                MEM_ACC: begin
                    if (bus.mem_ack) begin
                        if (load_hazard) begin
                            state <= LOAD_USE;
                            cnt   <= LOAD_USE_C;
                        end else begin
                            state <= RUN;
                        end
                    end else begin
                        tmo <= tmo_next;
                        if (int'(tmo_next) >= MEM_TIMEOUT)
                            timeout_flag <= 1'b1;
                    end
                end
                LOAD_USE, FLUSH: begin
                    cnt <= cnt - 8'd1;
                    if (cnt <= 8'd1)
                        state <= RUN;
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        stall = 1'b0;
        flush = 1'b0;
        owner = 1'b0;
        case (state)
            RUN:      flush = taken_run;
            MEM_ACC:  begin stall = 1'b1; owner = 1'b1; end
            LOAD_USE: stall = 1'b1;
            FLUSH:    flush = 1'b1;
            default:  ;
        endcase
    end

    assign bus.stall_if    = stall;
    assign bus.stall_id    = stall;
    assign bus.bubble_ex   = stall;
    assign bus.flush_if_id = flush;
    assign bus.flush_id_ex = flush;
    assign bus.sram_owner  = owner;
    assign bus.mem_timeout = timeout_flag;
    assign bus.ctrl_state  = state;

`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stat_stall_cnt;
    logic [31:0] stat_flush_cnt;

    pipe_sat_counter #(.DATA_W(32)) u_stat_stall (
        .clk   (clk),
        .rst   (rst),
        .en    (stall),
        .count (stat_stall_cnt)
    );

    pipe_sat_counter #(.DATA_W(32)) u_stat_flush (
        .clk   (clk),
        .rst   (rst),
        .en    (taken_run),
        .count (stat_flush_cnt)
    );

    assign bus.stat_stall = stat_stall_cnt;
    assign bus.stat_flush = stat_flush_cnt;
`else
    assign bus.stat_stall = '0;
    assign bus.stat_flush = '0;
`endif

endmodule
